// File: rtl/hsst_cap_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hsst_cap_pkg
// Purpose  : Shared definitions for the HSST frame-capture block.
//            - cap_state_e : capture FSM states (ARM is only reachable when
//                            the trigger option is compiled in)
//            - DROP_CNT_W  : width of the saturating drop counter
//            - lane_count(): number of sample lanes in one aligned word
// Revision : 1.0 - initial release
// ============================================================================
package hsst_cap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_FILL  = 2'd2,
    ST_DRAIN = 2'd3
  } cap_state_e;

  localparam int DROP_CNT_W = 16;

  function automatic int lane_count(input int in_w, input int sample_w);
    return in_w / sample_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hsst_cap_ram.sv
`default_nettype none
// ============================================================================
// Module   : hsst_cap_ram
// Purpose  : Simple dual-port RAM, DEPTH x W, one write port and one
//            synchronous read port, both on the same clock. Read data
//            appears one cycle after i_re and holds until the next read.
// Ports    : i_clk            clock
//            i_we/i_waddr/i_wdata   write port
//            i_re/i_raddr     read request
//            o_rdata          registered read data
// Revision : 1.0 - initial release
// ============================================================================
module hsst_cap_ram #(
  parameter int DEPTH = 256,
  parameter int W     = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/hsst_frame_capture.sv
`default_nettype none
// ============================================================================
// Module   : hsst_frame_capture
// Purpose  : Captures data-only (non-K) samples from the aligned HSST RX word
//            stream into a frame buffer, then drains the frame over a
//            valid/ready stream with a last marker.
// Ports    : sys_clk, rst_n (async, active-low)
//            in_data/in_k/in_valid     aligned word stream
//            cfg_en                    level, arms capture
//            cfg_lane_sel              sample lane within in_data
//            cfg_frame_len             samples per frame (0 or >DEPTH = DEPTH)
//            out_data/out_valid/out_last/out_ready   sample stream
//            busy                      capture or drain in progress
//            drop_cnt                  samples dropped while draining (sat.)
//            trig_level                only with HSST_CAP_TRIG_EN
// Options  : HSST_CAP_TRIG_EN - adds trig_level and an ARM state that waits
//            for a rising crossing of trig_level before filling.
// Revision : 1.0 - initial release
// ============================================================================
module hsst_frame_capture
  import hsst_cap_pkg::*;
#(
  parameter int  IN_W     = 32,
  parameter int  SAMPLE_W = 8,
  parameter int  DEPTH    = 256,
  parameter int  AW       = $clog2(DEPTH),
  localparam int LANES    = lane_count(IN_W, SAMPLE_W),
  localparam int LSW      = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic [IN_W-1:0]       in_data,
  input  logic [IN_W/8-1:0]     in_k,
  input  logic                  in_valid,
  input  logic                  cfg_en,
  input  logic [LSW-1:0]        cfg_lane_sel,
  input  logic [AW:0]           cfg_frame_len,
`ifdef HSST_CAP_TRIG_EN
  input  logic [SAMPLE_W-1:0]   trig_level,
`endif
  output logic [SAMPLE_W-1:0]   out_data,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  busy,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam logic [AW:0]           C_DEPTH    = (AW+1)'(DEPTH);
  localparam logic [AW:0]           C_ONE      = (AW+1)'(1);
  localparam logic [DROP_CNT_W-1:0] C_DROP_MAX = '1;

  cap_state_e            r_state;
  logic [AW:0]           r_flen;
  logic [AW-1:0]         r_wptr;
  logic [AW:0]           r_rptr;
  logic                  r_pend;
  logic                  r_pend_last;
  logic                  r_out_valid;
  logic                  r_out_last;
  logic [SAMPLE_W-1:0]   r_out_data;
  logic                  r_sk_valid;
  logic                  r_sk_last;
  logic [SAMPLE_W-1:0]   r_sk_data;
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  logic                  w_acc;
  logic [SAMPLE_W-1:0]   w_sample;
  logic [AW:0]           w_flen_cfg;
  logic [AW:0]           w_flen_m1;
  logic                  w_wr_last;
  logic                  w_we;
  logic                  w_pop;
  logic                  w_issue;
  logic [1:0]            w_occ;
  logic [SAMPLE_W-1:0]   w_rdata;

  assign w_acc      = in_valid && (in_k == '0);
  assign w_flen_cfg = ((cfg_frame_len == '0) || (cfg_frame_len > C_DEPTH)) ? C_DEPTH : cfg_frame_len;
  assign w_flen_m1  = r_flen - C_ONE;
  assign w_wr_last  = ({1'b0, r_wptr} == w_flen_m1);
  assign w_pop      = r_out_valid && out_ready;

  // Lanes that do not exist (non power-of-two lane count) fall back to lane 0.
  always_comb begin
    w_sample = in_data[SAMPLE_W-1:0];
    for (int n = 1; n < LANES; n++) begin
      if (cfg_lane_sel == LSW'(n)) begin
        w_sample = in_data[n*SAMPLE_W +: SAMPLE_W];
      end
    end
  end

`ifdef HSST_CAP_TRIG_EN
  logic r_have_prev;
  logic r_prev_lt;
  logic w_trig_hit;
  assign w_trig_hit = r_have_prev && r_prev_lt && (w_sample >= trig_level);
`endif

  always_comb begin
    w_we = 1'b0;
    case (r_state)
      ST_FILL: w_we = cfg_en && w_acc;
`ifdef HSST_CAP_TRIG_EN
      ST_ARM:  w_we = cfg_en && w_acc && w_trig_hit;
`endif
      default: w_we = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Capture FSM and write pointer
  // --------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_flen  <= C_DEPTH;
      r_wptr  <= '0;
`ifdef HSST_CAP_TRIG_EN
      r_have_prev <= 1'b0;
      r_prev_lt   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cfg_en) begin
            r_flen <= w_flen_cfg;
            r_wptr <= '0;
`ifdef HSST_CAP_TRIG_EN
            r_have_prev <= 1'b0;
            r_prev_lt   <= 1'b0;
            r_state     <= ST_ARM;
`else
            r_state <= ST_FILL;
`endif
          end
        end
`ifdef HSST_CAP_TRIG_EN
        ST_ARM: begin
          if (!cfg_en) begin
            r_state <= ST_IDLE;
          end else if (w_acc) begin
            if (w_trig_hit) begin
              // The crossing sample itself lands at address 0.
              r_wptr  <= AW'(1);
              r_state <= (r_flen == C_ONE) ? ST_DRAIN : ST_FILL;
            end else begin
              r_have_prev <= 1'b1;
              r_prev_lt   <= (w_sample < trig_level);
            end
          end
        end
`endif
        ST_FILL: begin
          if (!cfg_en) begin
            r_state <= ST_IDLE;
          end else if (w_acc) begin
            r_wptr <= r_wptr + AW'(1);
            if (w_wr_last) begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (w_pop && r_out_last) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Drain path: RAM read -> output register, with a one-entry skid so that a
  // read already in flight when the consumer stalls has somewhere to land.
  // A read is issued only if, counting it, at most two samples will be held
  // (output + skid) once it returns.
  // --------------------------------------------------------------------------
  assign w_occ   = 2'(r_out_valid) + 2'(r_sk_valid) + 2'(r_pend);
  assign w_issue = (r_state == ST_DRAIN) && (r_rptr < r_flen) &&
                   (w_pop ? (w_occ <= 2'd2) : (w_occ <= 2'd1));

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rptr      <= '0;
      r_pend      <= 1'b0;
      r_pend_last <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      r_sk_valid  <= 1'b0;
      r_sk_last   <= 1'b0;
      r_sk_data   <= '0;
    end else begin
      if (r_state == ST_IDLE) begin
        r_rptr <= '0;
      end else if (w_issue) begin
        r_rptr <= r_rptr + C_ONE;
      end
      r_pend      <= w_issue;
      r_pend_last <= w_issue && (r_rptr == w_flen_m1);

      if (!r_out_valid || w_pop) begin
        if (r_sk_valid) begin
          r_out_valid <= 1'b1;
          r_out_data  <= r_sk_data;
          r_out_last  <= r_sk_last;
          r_sk_valid  <= r_pend;
          r_sk_data   <= w_rdata;
          r_sk_last   <= r_pend_last;
        end else begin
          r_out_valid <= r_pend;
          r_out_last  <= r_pend && r_pend_last;
          if (r_pend) begin
            r_out_data <= w_rdata;
          end
        end
      end else if (r_pend) begin
        r_sk_valid <= 1'b1;
        r_sk_data  <= w_rdata;
        r_sk_last  <= r_pend_last;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if ((r_state == ST_DRAIN) && w_acc && (r_drop_cnt != C_DROP_MAX)) begin
      r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
    end
  end

  hsst_cap_ram #(
    .DEPTH (DEPTH),
    .W     (SAMPLE_W),
    .AW    (AW)
  ) u_ram (
    .i_clk   (sys_clk),
    .i_we    (w_we),
    .i_waddr (r_wptr),
    .i_wdata (w_sample),
    .i_re    (w_issue),
    .i_raddr (r_rptr[AW-1:0]),
    .o_rdata (w_rdata)
  );

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign busy      = (r_state != ST_IDLE);
  assign drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hsst_frame_capture.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_hsst_frame_capture
// Purpose  : Self-checking bench for hsst_frame_capture. A frame-level
//            reference model (sample queues and a phase tracker) predicts
//            every output sample, busy, drop_cnt and first-sample latency.
//            Define HSST_CAP_TRIG_EN to also exercise the trigger option.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hsst_frame_capture;

  localparam int DEPTH = 256;
  localparam int M_IDLE = 0, M_ARM = 1, M_FILL = 2, M_DRAIN = 3;

  logic        sys_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_data = '0;
  logic [3:0]  in_k = '0;
  logic        in_valid = 1'b0;
  logic        cfg_en = 1'b0;
  logic [1:0]  cfg_lane_sel = '0;
  logic [8:0]  cfg_frame_len = '0;
`ifdef HSST_CAP_TRIG_EN
  logic [7:0]  trig_level = '0;
`endif
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_ready = 1'b1;
  logic        busy;
  logic [15:0] drop_cnt;

  always #5 sys_clk = ~sys_clk;

  hsst_frame_capture dut (
    .sys_clk       (sys_clk),
    .rst_n         (rst_n),
    .in_data       (in_data),
    .in_k          (in_k),
    .in_valid      (in_valid),
    .cfg_en        (cfg_en),
    .cfg_lane_sel  (cfg_lane_sel),
    .cfg_frame_len (cfg_frame_len),
`ifdef HSST_CAP_TRIG_EN
    .trig_level    (trig_level),
`endif
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_last      (out_last),
    .out_ready     (out_ready),
    .busy          (busy),
    .drop_cnt      (drop_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  int         m_phase = M_IDLE;
  int         m_flen = 0;
  int         m_left = 0;
  int         m_age = 0;
  int         m_drops = 0;
  logic [7:0] m_frame[$];
  logic [8:0] exp_q[$];
  logic [7:0] m_prev = '0;
  bit         m_prev_ok = 0;
  int         rdy_mode = 0;
  bit         tog = 0;

  task automatic close_frame();
    for (int i = 0; i < m_flen; i++) begin
      exp_q.push_back({(i == m_flen - 1), m_frame[i]});
    end
    m_frame.delete();
    m_phase = M_DRAIN;
    m_left  = m_flen;
    m_age   = -1;
  endtask

  // One clock cycle: inputs are already set by the caller.
  task automatic step();
    bit         acc, hs, stall;
    logic [7:0] s, st_d;
    logic       st_l;
    logic [8:0] e;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       begin tog = !tog; out_ready = tog; end
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    acc = in_valid && (in_k == 4'h0);
    s   = 8'(in_data >> (8 * cfg_lane_sel));
    hs  = out_valid && out_ready;
    if (hs) begin
      chk("out_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("out_data", out_data, e[7:0]);
        chk("out_last", out_last, e[8]);
      end
    end
    stall = out_valid && !out_ready;
    st_d  = out_data;
    st_l  = out_last;

    case (m_phase)
      M_IDLE: begin
        if (cfg_en) begin
          m_flen = ((cfg_frame_len == 0) || (cfg_frame_len > DEPTH)) ? DEPTH : int'(cfg_frame_len);
          m_frame.delete();
          m_prev_ok = 0;
`ifdef HSST_CAP_TRIG_EN
          m_phase = M_ARM;
`else
          m_phase = M_FILL;
`endif
        end
      end
`ifdef HSST_CAP_TRIG_EN
      M_ARM: begin
        if (!cfg_en) begin
          m_phase = M_IDLE;
        end else if (acc) begin
          if (m_prev_ok && (m_prev < trig_level) && (s >= trig_level)) begin
            m_frame.push_back(s);
            m_phase = M_FILL;
            if (m_frame.size() == m_flen) close_frame();
          end else begin
            m_prev    = s;
            m_prev_ok = 1;
          end
        end
      end
`endif
      M_FILL: begin
        if (!cfg_en) begin
          m_phase = M_IDLE;
          m_frame.delete();
        end else if (acc) begin
          m_frame.push_back(s);
          if (m_frame.size() == m_flen) close_frame();
        end
      end
      default: begin
        if (acc && m_drops < 65535) m_drops++;
        if (hs) begin
          m_left--;
          if (m_left == 0) m_phase = M_IDLE;
        end
      end
    endcase

    @(posedge sys_clk);
    #1;
    if (stall) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, st_d);
      chk("stall_last", out_last, st_l);
    end
    chk("busy", busy, 32'(m_phase != M_IDLE));
    chk("drop_cnt", drop_cnt, m_drops);
    if (m_phase == M_DRAIN) begin
      m_age++;
      if (m_age < 2) chk("lat_early", out_valid, 0);
      else if (m_age == 2) chk("lat_first", out_valid, 1);
      else if (rdy_mode == 0) chk("throughput", out_valid, 1);
    end else begin
      chk("idle_valid", out_valid, 0);
    end
  endtask

  task automatic word(input logic v, input logic [3:0] k, input logic [31:0] d);
    in_valid = v;
    in_k     = k;
    in_data  = d;
    step();
  endtask

  task automatic start(input int flen, input int lane);
    cfg_frame_len = 9'(flen);
    cfg_lane_sel  = 2'(lane);
    cfg_en        = 1'b1;
    word(1'b0, 4'h0, $urandom);
  endtask

  task automatic fill_random(input bit gaps, input int maxc);
    int c = 0;
    while (m_phase != M_DRAIN && c < maxc) begin
      word(gaps ? 1'($urandom_range(0, 3) != 0) : 1'b1,
           (gaps && $urandom_range(0, 4) == 0) ? 4'h8 : 4'h0, $urandom);
      c++;
    end
    chk("fill_done", 32'(m_phase == M_DRAIN), 1);
  endtask

  task automatic finish(input bit feed, input int maxc);
    int c = 0;
    while ((m_phase != M_IDLE || exp_q.size() != 0) && c < maxc) begin
      if (feed) word(1'b1, ($urandom_range(0, 3) == 0) ? 4'h2 : 4'h0, $urandom);
      else      word(1'b0, 4'h0, $urandom);
      c++;
    end
    chk("drain_done", 32'(m_phase == M_IDLE && exp_q.size() == 0), 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    rst_n = 1'b1;
    @(posedge sys_clk);
    #1;

    // 1: basic 8-sample frame, lane 0, always ready
    rdy_mode = 0;
    start(8, 0);
    for (int i = 0; i < 8; i++) word(1'b1, 4'h0, 32'hA0 + 32'(i));
    cfg_en = 1'b0;
    finish(1'b0, 50);

    // 2: K words interleaved, lane 2
    start(4, 2);
    for (int i = 0; i < 8; i++) word(1'b1, (i % 2 == 0) ? 4'b0001 : 4'b0000, $urandom);
    cfg_en = 1'b0;
    finish(1'b0, 50);

    // 3: 16-sample frame with out_ready toggling
    rdy_mode = 1;
    start(16, $urandom_range(0, 3));
    fill_random(1'b1, 200);
    cfg_en = 1'b0;
    finish(1'b0, 200);

    // 4: full-depth frame with continuous input during drain
    rdy_mode = 0;
    start(0, $urandom_range(0, 3));
    fill_random(1'b0, 400);
    cfg_en = 1'b0;
    finish(1'b1, 600);
    chk("drops_nonzero", 32'(drop_cnt != 0), 1);

    // Oversize frame length clamps to DEPTH; random backpressure
    rdy_mode = 2;
    start(300, $urandom_range(0, 3));
    fill_random(1'b1, 800);
    cfg_en = 1'b0;
    finish(1'b0, 1200);

    // Random short frames
    for (int f = 0; f < 4; f++) begin
      start($urandom_range(1, 20), $urandom_range(0, 3));
      fill_random(1'b1, 200);
      cfg_en = 1'b0;
      finish(1'b1, 200);
    end

    // 5: abort in FILL, clean refill, reset mid-drain
    rdy_mode = 0;
    start(8, 0);
    for (int i = 0; i < 3; i++) word(1'b1, 4'h0, $urandom);
    cfg_en = 1'b0;
    for (int i = 0; i < 4; i++) word(1'b0, 4'h0, $urandom);
    start(8, 1);
    fill_random(1'b0, 50);
    cfg_en = 1'b0;
    finish(1'b0, 50);
    start(8, 3);
    fill_random(1'b0, 50);
    cfg_en = 1'b0;
    for (int i = 0; i < 4; i++) word(1'b0, 4'h0, $urandom);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_drop", drop_cnt, 0);
    m_phase = M_IDLE;
    m_drops = 0;
    exp_q.delete();
    m_frame.delete();
    @(posedge sys_clk);
    #2 rst_n = 1'b1;
    @(posedge sys_clk);
    #1;
    start(5, 0);
    fill_random(1'b0, 50);
    cfg_en = 1'b0;
    finish(1'b0, 50);

`ifdef HSST_CAP_TRIG_EN
    // 6: trigger on rising crossing of 0x80
    trig_level = 8'h80;
    start(4, 0);
    for (int v = 8'h70; v <= 8'h8F; v++) word(1'b1, 4'h0, 32'(v));
    cfg_en = 1'b0;
    finish(1'b0, 50);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
